// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates two requesters onto one shared, external,
// combinational ALU. Each grant runs IDLE -> EXEC -> DONE, so one operation
// completes every three cycles. Every output comes straight from a register.
// Op codes pass through unchanged. The shared constants header defines them as
// AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SLT=3'b111.
// Build option: define ALU_SCHED_RR_EN for round-robin arbitration between
// simultaneous requests. Without it, requester 0 has fixed priority.
module alu_scheduler #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   op0,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic         zero0,
  output logic         zero1,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_y,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nx;
  logic   take;    // grant happens at this edge
  logic   fire;    // result capture happens at this edge
  logic   pick1;   // requester 1 wins the current grant
  logic   owner;   // requester that owns the operation in flight

`ifdef ALU_SCHED_RR_EN
  logic last;      // last requester served

  // Round-robin: on a tie, favour the requester not served last time
  always_comb begin
    pick1 = req1;
    if (req0 && req1) pick1 = ~last;
  end

  // Last-served pointer moves at every grant
  always_ff @(posedge clk) begin
    if (rst)       last <= 1'b1;
    else if (take) last <= pick1;
  end
`else
  // Fixed priority: requester 0 wins any tie
  always_comb begin
    pick1 = req1 & ~req0;
  end
`endif

  // Next-state and strobe decode; requests are only looked at in IDLE
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        fire     = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Handshake pulses and busy flag, registered so they line up with the state
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack0  <= take & ~pick1;
      ack1  <= take & pick1;
      done0 <= fire & ~owner;
      done1 <= fire & owner;
      busy  <= (state_nx != IDLE);
    end
  end

  // ALU drive and owner are loaded at grant and hold between operations
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 3'b000;
      owner    <= 1'b0;
    end else if (take) begin
      alu_a    <= pick1 ? a1 : a0;
      alu_b    <= pick1 ? b1 : b0;
      alu_ctrl <= pick1 ? op1 : op0;
      owner    <= pick1;
    end
  end

  // Per-requester result registers; only the owner's copy is updated
  always_ff @(posedge clk) begin
    if (rst) begin
      y0    <= '0;
      y1    <= '0;
      zero0 <= 1'b0;
      zero1 <= 1'b0;
    end else if (fire) begin
      if (owner) begin
        y1    <= alu_y;
        zero1 <= alu_zero;
      end else begin
        y0    <= alu_y;
        zero0 <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed testbench for alu_scheduler, with a behavioural model of the
// shared combinational ALU.
module tb_alu_scheduler;
  localparam int W = 32;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, done0, done1;
  logic [W-1:0] y0, y1;
  logic         zero0, zero1, busy;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_y;
  logic         alu_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_scheduler #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .y0(y0), .y1(y1), .zero0(zero0), .zero1(zero1), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model
  always_comb begin
    alu_y = '0;
    case (alu_ctrl)
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_SLT:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = '0;
    endcase
    alu_zero = (alu_y == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an ack; who = 0/1, or -1 on timeout
  task automatic wait_ack(output int who);
    int k;
    k   = 0;
    who = -1;
    while (who < 0 && k < 10) begin
      tick();
      k++;
      if (ack0 && ack1) chk("ack_both", 1, 0);
      if (ack0) who = 0;
      else if (ack1) who = 1;
    end
    if (who < 0) chk("ack_timeout", 1, 0);
  endtask

  initial begin
    int who, t1;
    rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(); tick();
    chk("rst_ack",   {ack0, ack1}, 0);
    chk("rst_done",  {done0, done1}, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_y0",    y0, 0);
    chk("rst_y1",    y1, 0);
    chk("rst_zero",  {zero0, zero1}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ctrl",  alu_ctrl, 0);
    rst = 1'b0;

    // req0 ADD 8 + 41
    req0 = 1; op0 = OP_ADD; a0 = 8; b0 = 41;
    tick();
    chk("add_ack0", {ack0, ack1}, 2'b10);
    chk("add_busy1", busy, 1);
    chk("add_alu_a", alu_a, 8);
    chk("add_alu_b", alu_b, 41);
    chk("add_ctrl", alu_ctrl, OP_ADD);
    chk("add_nodone", done0, 0);
    req0 = 0;
    tick();
    chk("add_done", {done0, done1, ack0}, 3'b100);
    chk("add_y0", y0, 49);
    chk("add_zero0", zero0, 0);
    chk("add_busy2", busy, 1);
    tick();
    chk("add_idle", {done0, busy}, 0);

    // req1 SUB 41 - 41
    req1 = 1; op1 = OP_SUB; a1 = 41; b1 = 41;
    tick();
    chk("sub_ack1", {ack0, ack1}, 2'b01);
    req1 = 0;
    tick();
    chk("sub_done", {done0, done1}, 2'b01);
    chk("sub_y1", y1, 0);
    chk("sub_zero1", zero1, 1);
    chk("sub_y0_kept", y0, 49);
    tick();

    // Simultaneous SLT, both held
    req0 = 1; op0 = OP_SLT; a0 = 32'hFFFFFFFD; b0 = 32'hFFFFFFFB;
    req1 = 1; op1 = OP_SLT; a1 = 32'hFFFFFFFB; b1 = 32'hFFFFFFFD;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
`ifdef ALU_SCHED_RR_EN
      chk("slt_winner", who, i % 2);
`else
      chk("slt_winner", who, 0);
`endif
      tick();
      if (who == 0) begin
        chk("slt_done0", {done0, done1}, 2'b10);
        chk("slt_y0", y0, 0);
        chk("slt_zero0", zero0, 1);
      end else begin
        chk("slt_done1", {done0, done1}, 2'b01);
        chk("slt_y1", y1, 1);
      end
    end
    req0 = 0; req1 = 0;
    tick(); tick();

    // Back-to-back AND on requester 0
    req0 = 1; op0 = OP_AND; a0 = 32'hF0F0; b0 = 32'hFF00;
    wait_ack(who);
    chk("and1_who", who, 0);
    t1 = cyc;
    tick();
    chk("and1_y0", y0, 32'hF000);
    wait_ack(who);
    chk("and2_who", who, 0);
    chk("and_spacing", cyc - t1, 3);
    req0 = 0;
    tick();
    chk("and2_done", done0, 1);
    chk("and2_y0", y0, 32'hF000);
    tick(); tick();

    // Reset during EXEC aborts the operation
    req0 = 1; op0 = OP_ADD; a0 = 5; b0 = 6;
    wait_ack(who);
    chk("abort_who", who, 0);
    rst = 1; req1 = 1; op1 = OP_OR; a1 = 1; b1 = 2;
    tick();
    chk("abort_nodone", {done0, done1}, 0);
    chk("abort_y0", y0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_noack", {ack0, ack1}, 0);
    rst = 0;
    tick();
    chk("post_rst_ack", {ack0, ack1}, 2'b10);
    req0 = 0; req1 = 0;
    tick();
    chk("post_rst_done", {done0, done1}, 2'b10);
    chk("post_rst_y0", y0, 11);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter W, default 32, operand/result data width; the block SHALL be verified at W=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 op0, op1  input  3 each  ALU control code (AND/OR/ADD/SUB/SLT per shared constants header).
REQ-006 a0, b0, a1, b1  input  W each  operands of requester 0 / 1.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result valid on y/zero.
REQ-009 y0, y1  output  W each; zero0, zero1  output  1 each  per-requester result registers.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 alu_a, alu_b  output  W each; alu_ctrl  output  3  drive to the shared ALU, registered.
REQ-012 alu_y  input  W; alu_zero  input  1  combinational ALU result/zero flag.

Function
REQ-013 FSM states: IDLE, EXEC, DONE; all outputs SHALL be registered.
REQ-014 IDLE, no req: remain IDLE, ALU drive registers hold last values.
REQ-015 IDLE, any req at edge: select winner, load alu_a/alu_b/alu_ctrl from winner's a/b/op, set owner, pulse ack of winner next cycle, go EXEC.
REQ-016 EXEC (one cycle): at edge, capture alu_y/alu_zero into winner's y/zero, pulse winner's done next cycle, go DONE.
REQ-017 DONE (one cycle): go IDLE unconditionally; requests are not sampled in DONE or EXEC.
REQ-018 Latency: req sampled at edge N -> ack high cycle N+1 -> done and result valid cycle N+2; next request sampled at edge ending N+3; throughput one op per 3 cycles.
REQ-019 Requester SHALL hold req/op/a/b stable until ack; a req still high in IDLE after its done is a new request.
REQ-020 y/zero of a requester SHALL hold until that requester's next done; non-owner's y/zero unchanged.
REQ-021 ack0/ack1 never high together; done0/done1 never high together.
REQ-022 op codes are forwarded unmodified; result for any op is whatever the ALU returns.
REQ-023 Single requester active: it wins regardless of arbitration mode.

Reset
REQ-024 rst at edge SHALL force IDLE, ack*/done*/busy=0, y0=y1=0, zero0=zero1=0, alu_a=alu_b=0, alu_ctrl=0, last-served pointer=1.
REQ-025 rst in EXEC or DONE aborts the operation: no done pulse, results not updated (cleared to 0).
REQ-026 rst dominates requests in the same cycle; first grant occurs no earlier than the edge after rst deasserts.

Configuration
REQ-027 Macro ALU_SCHED_RR_EN defined: round-robin -- on simultaneous req, winner is requester not last served; pointer updates at each grant.
REQ-028 ALU_SCHED_RR_EN undefined: fixed priority -- req0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-029 req0 ADD a0=8 b0=41 -> ack0 at N+1, done0 at N+2, y0=49, zero0=0, busy high N+1..N+2.
REQ-030 req1 SUB a1=41 b1=41 -> done1, y1=0, zero1=1; y0 unchanged from prior value.
REQ-031 req0 SLT a0=0xFFFFFFFD b0=0xFFFFFFFB and req1 SLT a1=0xFFFFFFFB b1=0xFFFFFFFD held simultaneously, RR build -> done0 y0=0 first, then done1 y1=1, grants alternate 0,1,0,1.
REQ-032 Same stimulus, fixed-priority build, req0 held high continuously -> only ack0/done0 observed, req1 never acked.
REQ-033 rst asserted during EXEC of req0 ADD 5+6 -> no done0, y0=0, state IDLE, next grant after rst low goes to req0 when both request.
REQ-034 req0 AND 0xF0F0 & 0xFF00 issued back-to-back -> second ack exactly 3 cycles after first, y0=0xF000 both times.
